handshake_responder: RTL



---
 rtl/handshake_responder_pkg.sv | 23 ++
 rtl/handshake_responder_if.sv | 23 ++
 rtl/handshake_responder_sync_bit.sv | 27 ++
 rtl/handshake_responder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/handshake_responder_pkg.sv
// Shared handshake definitions: state encoding common to the initiator and
// responder FSMs, default timing constants and a counter-width helper.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        ACK     = 2'd2
    } hs_state_t;

    localparam int HS_SYNC_STAGES    = 2;
    localparam int HS_SERVICE_CYCLES = 4;
    localparam int HS_TIMEOUT_CYCLES = 1024;
    localparam int HS_CNT_W          = 8;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/handshake_responder_if.sv
// Four-phase request/acknowledge link between initiator (devA) and responder (devB).
interface handshake_responder_if;

    // devA rises to request; devB rises once the request is served; devA
    // falls only after devB is seen high; devB falls only after devA is seen
    // low. Either side may be asynchronous to the other's clock.
    logic devA;
    logic accept;
    logic devB;

    modport master (
        output devA,
        output accept,
        input  devB
    );

    modport slave (
        input  devA,
        input  accept,
        output devB
    );

endinterface

// File: rtl/handshake_responder_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level, cleared by async reset.
module sync_bit
    import hs_pkg::*;
#(
    parameter int SYNC_STAGES = HS_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/handshake_responder.sv
// Device-B responder: serves a synchronized devA request for a minimum period,
// waits for a local accept, acknowledges on devB and releases after devA falls.
module handshake_responder
    import hs_pkg::*;
#(
    parameter int SYNC_STAGES    = HS_SYNC_STAGES,
    parameter int SERVICE_CYCLES = HS_SERVICE_CYCLES,
    parameter int TIMEOUT_CYCLES = HS_TIMEOUT_CYCLES,
    parameter int CNT_W          = HS_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    handshake_responder_if.slave hs,
    output logic             LED_devA,
    output logic             LED_ack,
    output logic [CNT_W-1:0] xfer_count,
    output logic             err,
    output hs_state_t        state
);

    localparam int SVC_MAX = (SERVICE_CYCLES < 1) ? 1 : SERVICE_CYCLES;
    localparam int SVC_W   = cnt_width(SVC_MAX);
    localparam int TO_W    = cnt_width(TIMEOUT_CYCLES);

    localparam logic [SVC_W-1:0] SVC_LOAD = SVC_W'(SVC_MAX - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

    logic devA_s;
    logic accept_s;

    hs_state_t        state_next;
    logic [SVC_W-1:0] svc_cnt;
    logic [SVC_W-1:0] svc_next;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_next;
    logic             cnt_inc;
    logic             err_set;
    logic             devB_q;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_devA (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hs.devA),
        .q     (devA_s)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_accept (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hs.accept),
        .q     (accept_s)
    );

    always_comb begin
        state_next = state;
        svc_next   = svc_cnt;
        to_next    = to_cnt;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (devA_s) begin
                    state_next = SERVICE;
                    svc_next   = SVC_LOAD;
                end
            end
            SERVICE: begin
                // Request withdrawn before we acknowledged it: protocol error.
                if (!devA_s) begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end else if (svc_cnt != '0) begin
                    svc_next = svc_cnt - SVC_W'(1);
                end else if (accept_s) begin
                    state_next = ACK;
                    to_next    = '0;
                end
            end
            ACK: begin
                if (!devA_s) begin
                    state_next = IDLE;
                    cnt_inc    = 1'b1;
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    // Initiator is stuck high; flag it but keep acknowledging.
                    err_set = 1'b1;
                end else if (TO_EN) begin
                    to_next = to_cnt + TO_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            svc_cnt    <= '0;
            to_cnt     <= '0;
            devB_q     <= 1'b0;
            xfer_count <= '0;
            err        <= 1'b0;
        end else begin
            state   <= state_next;
            svc_cnt <= svc_next;
            to_cnt  <= to_next;
            devB_q  <= (state_next == ACK);
            if (cnt_inc) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign hs.devB  = devB_q;
    assign LED_ack  = devB_q;
    assign LED_devA = devA_s;

endmodule
